// File: rtl/decompressor_pkg.sv
// Shared types and frame geometry for the decompressor back end.
// Used by rgb_frame_reader (optional Checksum port under RGB_READER_CHECKSUM_EN).
package decompressor_pkg;

  localparam int unsigned SRAM_AW        = 18;
  localparam int unsigned RGB_BASE       = 146944;
  localparam int unsigned IMG_W          = 320;
  localparam int unsigned IMG_H          = 240;
  localparam int unsigned RGB_RD_LATENCY = 2;
  localparam int unsigned RGB_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} rgb_reader_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_pixel_t;

endpackage

// File: rtl/rgb_pixel_fifo.sv
// First-word-fall-through pixel FIFO; depth must be a power of two.
module rgb_pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CW-1:0]    count_next_c;

  // A push into a full FIFO is only taken when a pop frees the slot this cycle
  assign do_pop_c     = pop && !empty;
  assign do_push_c    = push && (!full || do_pop_c);
  assign count_next_c = count + CW'(do_push_c) - CW'(do_pop_c);
  assign pop_data     = mem[rd_ptr];

  always_ff @(posedge Clock) begin
    if (do_push_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next_c;
      full  <= (count_next_c == CW'(DEPTH));
      empty <= (count_next_c == '0);
    end
  end

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads the packed RGB frame from SRAM and streams one {R,G,B} pixel per handshake.
// RGB_READER_CHECKSUM_EN adds a running R+G+B Checksum output.
module rgb_frame_reader
  import decompressor_pkg::*;
#(
  parameter int unsigned FRAME_BASE = RGB_BASE,
  parameter int unsigned FRAME_W    = IMG_W,
  parameter int unsigned FRAME_H    = IMG_H,
  parameter int unsigned RD_LATENCY = RGB_RD_LATENCY,
  parameter int unsigned FIFO_DEPTH = RGB_FIFO_DEPTH
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [23:0] Pixel_data,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic        Pixel_sof,
  output logic        Pixel_eol,
  output logic        Busy,
  output logic        Done
`ifdef RGB_READER_CHECKSUM_EN
  ,
  output logic [15:0] Checksum
`endif
);

  localparam int unsigned AW     = SRAM_AW;
  localparam int unsigned NWORDS = FRAME_W * FRAME_H * 3 / 2;
  localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

  rgb_reader_state_t        state;
  logic [AW-1:0]            word_cnt;
  logic [1:0]               grp_ph;
  logic [CW-1:0]            reserved;
  logic [RD_LATENCY:0]      tag_vld;
  logic [RD_LATENCY:0][1:0] tag_ph;
  logic [7:0]               r0, g0, r1;
  logic [15:0]              x, y;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  rgb_pixel_t    push_pix_c, pop_pix;
  logic          push_c, pop_c;
  logic [CW-1:0] free_c;
  logic          issue_c, start_grp_c, last_word_c, last_pix_c;
  logic          ret_vld_c;
  logic [1:0]    ret_ph_c;

  // A group needs two free slots not already promised to words in flight
  assign free_c      = CW'(FIFO_DEPTH) - fifo_count - reserved;
  assign issue_c     = (state == FETCH) && ((grp_ph != 2'd0) || (free_c >= CW'(2)));
  assign start_grp_c = issue_c && (grp_ph == 2'd0);
  assign last_word_c = (word_cnt == AW'(NWORDS - 1));

  assign ret_vld_c  = tag_vld[RD_LATENCY];
  assign ret_ph_c   = tag_ph[RD_LATENCY];
  assign push_c     = ret_vld_c && (ret_ph_c != 2'd0);
  assign push_pix_c = (ret_ph_c == 2'd1)
                    ? rgb_pixel_t'({r0, g0, SRAM_read_data[15:8]})
                    : rgb_pixel_t'({r1, SRAM_read_data});

  assign pop_c      = Pixel_valid && Pixel_ready;
  assign last_pix_c = pop_c && (x == 16'(FRAME_W - 1)) && (y == 16'(FRAME_H - 1));

  assign SRAM_we_n   = 1'b1;
  assign Pixel_valid = !fifo_empty;
  assign Pixel_data  = pop_pix;
  assign Pixel_sof   = Pixel_valid && (x == 16'd0) && (y == 16'd0);
  assign Pixel_eol   = Pixel_valid && (x == 16'(FRAME_W - 1));

  rgb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (24)
  ) u_fifo (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .push      (push_c),
    .push_data (push_pix_c),
    .pop       (pop_c),
    .pop_data  (pop_pix),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame control FSM
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE:  if (Start) begin
                 state <= FETCH;
                 Busy  <= 1'b1;
               end
        FETCH: if (issue_c && last_word_c) state <= DRAIN;
        DRAIN: if (last_pix_c) begin
                 state <= DONE;
                 Busy  <= 1'b0;
                 Done  <= 1'b1;
               end
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address issue, credit accounting and return-phase tagging
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address <= '0;
      word_cnt     <= '0;
      grp_ph       <= '0;
      reserved     <= '0;
      tag_vld      <= '0;
      tag_ph       <= '0;
    end else begin
      if ((state == IDLE) && Start) begin
        word_cnt <= '0;
        grp_ph   <= '0;
      end
      if (issue_c) begin
        SRAM_address <= AW'(FRAME_BASE) + word_cnt;
        word_cnt     <= word_cnt + AW'(1);
        grp_ph       <= (grp_ph == 2'd2) ? 2'd0 : grp_ph + 2'd1;
      end
      reserved <= reserved + (start_grp_c ? CW'(2) : CW'(0)) - (push_c ? CW'(1) : CW'(0));
      tag_vld  <= {tag_vld[RD_LATENCY-1:0], issue_c};
      tag_ph   <= {tag_ph[RD_LATENCY-1:0], grp_ph};
    end
  end

  // Unpacker holding registers for the partial pixels of a group
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r0 <= '0;
      g0 <= '0;
      r1 <= '0;
    end else if (ret_vld_c) begin
      if (ret_ph_c == 2'd0) begin
        r0 <= SRAM_read_data[15:8];
        g0 <= SRAM_read_data[7:0];
      end else if (ret_ph_c == 2'd1) begin
        r1 <= SRAM_read_data[7:0];
      end
    end
  end

  // Raster position of the pixel at the FIFO head
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      x <= '0;
      y <= '0;
    end else if ((state == IDLE) && Start) begin
      x <= '0;
      y <= '0;
    end else if (pop_c) begin
      if (x == 16'(FRAME_W - 1)) begin
        x <= '0;
        y <= (y == 16'(FRAME_H - 1)) ? 16'd0 : y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

`ifdef RGB_READER_CHECKSUM_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Checksum <= '0;
    end else if ((state == IDLE) && Start) begin
      Checksum <= '0;
    end else if (pop_c) begin
      Checksum <= Checksum + 16'(pop_pix.r) + 16'(pop_pix.g) + 16'(pop_pix.b);
    end
  end
`endif

  // Credits must make this unreachable
  a_no_overflow: assert property (@(posedge Clock) disable iff (!Resetn)
    !(push_c && fifo_full && !pop_c))
    else $error("rgb_frame_reader pixel fifo overflow");

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Self-checking bench for rgb_frame_reader on a reduced frame ending at SRAM word 18'h3FFFF.
module tb_rgb_frame_reader;

  localparam int W      = 16;
  localparam int H      = 8;
  localparam int NPIX   = W * H;
  localparam int NWORDS = NPIX * 3 / 2;
  localparam int BASE   = 262144 - NWORDS;

  logic        Clock, Resetn, Start, Pixel_ready;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n, Pixel_valid, Pixel_sof, Pixel_eol, Busy, Done;
  logic [23:0] Pixel_data;
`ifdef RGB_READER_CHECKSUM_EN
  logic [15:0] Checksum;
`endif

  rgb_frame_reader #(
    .FRAME_BASE (BASE),
    .FRAME_W    (W),
    .FRAME_H    (H),
    .RD_LATENCY (2),
    .FIFO_DEPTH (8)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Start          (Start),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_address   (SRAM_address),
    .SRAM_we_n      (SRAM_we_n),
    .Pixel_data     (Pixel_data),
    .Pixel_valid    (Pixel_valid),
    .Pixel_ready    (Pixel_ready),
    .Pixel_sof      (Pixel_sof),
    .Pixel_eol      (Pixel_eol),
    .Busy           (Busy),
    .Done           (Done)
`ifdef RGB_READER_CHECKSUM_EN
    ,
    .Checksum       (Checksum)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] img [NWORDS];
  logic [15:0] d1, d2;
  int  rdy_mode = 0;
  bit  mon_en   = 0;
  int  pix_idx, eol_cnt, done_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel p from the pair packing {R0,G0},{B0,R1},{G1,B1}
  function automatic logic [23:0] model_pix(input int p);
    int w;
    logic [15:0] a, b, c;
    w = 3 * (p / 2);
    a = img[w];
    b = img[w + 1];
    c = img[w + 2];
    if (p % 2 == 0) return {a, b[15:8]};
    return {b[7:0], c};
  endfunction

  function automatic logic [15:0] sram_word(input logic [17:0] a);
    if (int'(a) >= BASE) return img[int'(a) - BASE];
    return 16'hDEAD;
  endfunction

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  // SRAM: data for a registered address is valid two cycles later
  always @(posedge Clock) begin
    d1 <= sram_word(SRAM_address);
    d2 <= d1;
  end
  assign SRAM_read_data = d2;

  initial begin
    Pixel_ready = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      case (rdy_mode)
        0: Pixel_ready = 1'b1;
        1: Pixel_ready = ($urandom_range(0, 99) < 30);
        default: Pixel_ready = 1'b0;
      endcase
    end
  end

  // Accept monitor, sampled mid-cycle
  always @(negedge Clock) begin
    if (Done) done_cnt++;
    if (mon_en && Pixel_valid && Pixel_ready) begin
      if (pix_idx >= NPIX) begin
        check("extra_pixel", 64'(pix_idx), 64'(NPIX - 1));
      end else begin
        check("pixel", {Pixel_sof, Pixel_eol, Pixel_data},
              {pix_idx == 0, (pix_idx % W) == W - 1, model_pix(pix_idx)});
      end
      if (Pixel_eol) eol_cnt++;
      pix_idx++;
    end
  end

  task automatic begin_frame();
    pix_idx  = 0;
    eol_cnt  = 0;
    done_cnt = 0;
    mon_en   = 1;
    @(posedge Clock); #1;
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (pix_idx < n && k < budget) begin
      @(posedge Clock); #1;
      k++;
    end
    check("wait_pix_timeout", 64'(pix_idx >= n), 64'd1);
  endtask

  task automatic finish_frame(input int budget);
    int k = 0;
    while (!Done && k < budget) begin
      @(posedge Clock); #1;
      k++;
    end
    check("done_seen", 64'(Done), 64'd1);
    check("busy_at_done", 64'(Busy), 64'd0);
    repeat (4) begin @(posedge Clock); #1; end
    check("pixel_count", 64'(pix_idx), 64'(NPIX));
    check("eol_count", 64'(eol_cnt), 64'(H));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("last_addr", 64'(SRAM_address), 64'h3FFFF);
    check("busy_idle", 64'(Busy), 64'd0);
    mon_en = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 64'(SRAM_address), 64'd0);
    check({tag, "_we_n"}, 64'(SRAM_we_n), 64'd1);
    check({tag, "_valid"}, 64'(Pixel_valid), 64'd0);
    check({tag, "_sof_eol"}, 64'({Pixel_sof, Pixel_eol}), 64'd0);
    check({tag, "_busy_done"}, 64'({Busy, Done}), 64'd0);
  endtask

  initial begin
    int first;
    logic [17:0] a0;
    logic [23:0] p0;
    logic [15:0] exp_sum;

    Resetn = 1'b0;
    Start  = 1'b0;
    for (int i = 0; i < NWORDS; i++) img[i] = 16'(i);
    repeat (3) @(posedge Clock);
    #1;
    check_reset_outputs("reset");
    Resetn = 1'b1;

    // Word-index image: latency, first two pixels, full frame
    begin_frame();
    first = -1;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) begin @(posedge Clock); #1; end
      if (n == 1) check("busy_after_start", 64'(Busy), 64'd1);
      if (n == 2) check("first_addr", 64'(SRAM_address), 64'(BASE));
      if (Pixel_valid && first < 0) first = n;
      if (n == 6) check("pix0", 64'({Pixel_sof, Pixel_data}), {39'd0, 1'b1, 24'h000000});
      if (n == 7) check("pix1", 64'({Pixel_sof, Pixel_data}), {39'd0, 1'b0, 24'h010002});
    end
    check("first_valid_cycle", 64'(first), 64'd6);
    finish_frame(2000);

    // Output stall mid-row: fetch must stop once credits are gone
    for (int i = 0; i < NWORDS; i++) img[i] = 16'($urandom);
    begin_frame();
    wait_pix(20, 500);
    rdy_mode = 2;
    repeat (20) begin @(posedge Clock); #1; end
    a0 = SRAM_address;
    p0 = Pixel_data;
    repeat (30) begin @(posedge Clock); #1; end
    check("stall_addr_hold", 64'(SRAM_address), 64'(a0));
    check("stall_data_hold", 64'(Pixel_data), 64'(p0));
    check("stall_valid", 64'(Pixel_valid), 64'd1);
    rdy_mode = 0;
    finish_frame(2000);

    // Random backpressure over a whole frame
    for (int i = 0; i < NWORDS; i++) img[i] = 16'($urandom);
    rdy_mode = 1;
    begin_frame();
    finish_frame(8000);
    rdy_mode = 0;

    // Reset mid-frame, then a clean restart
    begin_frame();
    wait_pix(60, 500);
    Resetn = 1'b0;
    mon_en = 0;
    @(posedge Clock); #1;
    check_reset_outputs("abort");
    Resetn = 1'b1;
    begin_frame();
    @(posedge Clock); #1;
    check("restart_addr", 64'(SRAM_address), 64'(BASE));
    finish_frame(2000);

    // Saturated image, plus a Start pulse while busy that must be ignored
    for (int i = 0; i < NWORDS; i++) img[i] = 16'hFFFF;
    exp_sum = '0;
    for (int p = 0; p < NPIX; p++) begin
      p0 = model_pix(p);
      exp_sum = exp_sum + 16'(p0[23:16]) + 16'(p0[15:8]) + 16'(p0[7:0]);
    end
    begin_frame();
    wait_pix(30, 500);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    finish_frame(2000);
`ifdef RGB_READER_CHECKSUM_EN
    check("checksum", 64'(Checksum), 64'(exp_sum));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
